// File: rtl/add_operand_loader.sv
// Byte-serial operand loader for the 20-bit ripple adder: assembles A, cin and B, then holds them for the adder.
// Optional even-parity checking on the byte bus is enabled by defining ADD_LOADER_PARITY_EN.
module add_operand_loader #(
  parameter int WIDTH  = 20,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_cin,
`ifdef ADD_LOADER_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  a_out,
  output logic [WIDTH-1:0]  b_out,
  output logic              cin_out,
  output logic              busy
);

  localparam int NBYTES = (WIDTH + BYTE_W - 1) / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_cin_sh;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_a_out;
  logic [WIDTH-1:0]   r_b_out;
  logic               r_cin_out;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_last;
  logic               w_final_b;
  logic [WIDTH-1:0]   w_merged;

  // Bits of the last byte that fall above WIDTH have no destination and are dropped here.
  function automatic logic [WIDTH-1:0] merge_byte(input logic [WIDTH-1:0] sh,
                                                  input logic [CNT_W-1:0] idx,
                                                  input logic [BYTE_W-1:0] data);
    logic [WIDTH-1:0] res;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i / BYTE_W) == int'(idx)) res[i] = data[i % BYTE_W];
      else                           res[i] = sh[i];
    end
    return res;
  endfunction

  assign w_last    = (r_cnt == CNT_W'(NBYTES - 1));
  assign w_final_b = w_in_xfer && (r_state == LOAD_B) && w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD_A;
    else        r_state <= w_state_next;
  end

  // Next-state, handshake and busy decode
  always_comb begin
    w_state_next = r_state;
    w_in_xfer    = 1'b0;
    w_out_xfer   = 1'b0;
    in_ready     = 1'b0;
    case (r_state)
      LOAD_A: begin
        in_ready  = 1'b1;
        w_in_xfer = in_valid;
        if (in_valid && w_last) w_state_next = LOAD_B;
        else                    w_state_next = LOAD_A;
      end
      LOAD_B: begin
        in_ready  = 1'b1;
        w_in_xfer = in_valid;
        if (in_valid && w_last) w_state_next = ISSUE;
        else                    w_state_next = LOAD_B;
      end
      ISSUE: begin
        w_out_xfer = out_ready;
        if (out_ready) w_state_next = LOAD_A;
        else           w_state_next = ISSUE;
      end
      default: w_state_next = LOAD_A;
    endcase
    busy = (r_state != LOAD_A) || (r_cnt != {CNT_W{1'b0}});
  end

  // Incoming byte merged into whichever shadow is being loaded
  always_comb begin
    w_merged = {WIDTH{1'b0}};
    if (r_state == LOAD_A) w_merged = merge_byte(r_a_sh, r_cnt, in_data);
    else                   w_merged = merge_byte(r_b_sh, r_cnt, in_data);
  end

  // Shadow loading, byte counter and registered adder-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_a_sh      <= {WIDTH{1'b0}};
      r_b_sh      <= {WIDTH{1'b0}};
      r_cin_sh    <= 1'b0;
      r_out_valid <= 1'b0;
      r_a_out     <= {WIDTH{1'b0}};
      r_b_out     <= {WIDTH{1'b0}};
      r_cin_out   <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        if (r_state == LOAD_A) begin
          r_a_sh <= w_merged;
          if (r_cnt == {CNT_W{1'b0}}) r_cin_sh <= in_cin;
        end else begin
          r_b_sh <= w_merged;
        end
        if (w_last) r_cnt <= {CNT_W{1'b0}};
        else        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_final_b) begin
        r_a_out     <= r_a_sh;
        r_b_out     <= w_merged;
        r_cin_out   <= r_cin_sh;
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign cin_out   = r_cin_out;

`ifdef ADD_LOADER_PARITY_EN
  logic r_par_sticky;
  logic r_par_err;
  logic w_par_bad;

  function automatic logic parity_odd(input logic [BYTE_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

  assign w_par_bad = parity_odd(in_data, in_par);

  // Sticky per-set parity error, published alongside the operand copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_sticky <= 1'b0;
      r_par_err    <= 1'b0;
    end else if (w_final_b) begin
      r_par_err    <= r_par_sticky | w_par_bad;
      r_par_sticky <= 1'b0;
    end else if (w_in_xfer && w_par_bad) begin
      r_par_sticky <= 1'b1;
    end else begin
      r_par_sticky <= r_par_sticky;
    end
  end

  assign par_err = r_par_err;
`endif

endmodule
